hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
- Controls the execute stage.
- Generates the two forwarding-mux selects for the ALU sources.
- Detects RAW and load-use hazards and asserts a stall (freeze IF/ID, bubble into ID/EX).
- Sequences a multi-cycle memory-wait freeze of the whole pipeline.
- Sits beside the ID/EX/MEM/WB pipeline registers; its outputs drive the EX-stage source-select muxes and the freeze/flush enables of the pipeline registers.

Parameters:
MEM_WAIT, 2, freeze cycles per MEM-stage load/store (0 = single-cycle memory)
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
idSrc1  input  4  ID-stage source register 1 (Rn)
idSrc2  input  4  ID-stage source register 2 (Rm/Rd for store)
idUsesSrc1  input  1  ID instruction reads idSrc1
idUsesSrc2  input  1  ID instruction reads idSrc2
idValid  input  1  ID holds a real instruction
exeDest  input  4  EX-stage destination
exeWbEn  input  1  EX-stage instruction writes back
exeMemREn  input  1  EX-stage instruction is a load
memDest  input  4  MEM-stage destination
memWbEn  input  1  MEM-stage instruction writes back
memAccess  input  1  MEM-stage instruction is a load or store
wbDest  input  4  WB-stage destination
wbWbEn  input  1  WB-stage instruction writes back
selSrc1  output  2  ALU src1 select: 00 ID value, 01 MEM aluRes, 10 WB value
selSrc2  output  2  ALU src2 select, same encoding
hazardStall  output  1  hold PC and IF/ID; insert bubble into ID/EX
memFreeze  output  1  hold all pipeline registers
stallCount  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: all internal registers clear; FSM goes to IDLE; stallCount = 0. After reset, selSrc1 = selSrc2 = 00 and hazardStall = memFreeze = 0 for one cycle while all inputs are 0.
- EX source tracking: registers exSrc1, exSrc2, exUses1, exUses2 model the instruction in EX. Each rising edge:
  - memFreeze=1: hold.
  - else hazardStall=1: load bubble (exUses1 = exUses2 = 0).
  - else: load idSrc*, and idUses* & idValid.
- Forwarding (combinational from the EX registers):
  - selSrcN = 01 if exUsesN & memWbEn & memDest == exSrcN.
  - else 10 if exUsesN & wbWbEn & wbDest == exSrcN.
  - else 00.
  - MEM has priority over WB when both match.
- Load-use hazard: hazardStall = idValid & exeWbEn & exeMemREn & ((idUsesSrc1 & idSrc1 == exeDest) | (idUsesSrc2 & idSrc2 == exeDest)). This gives exactly one bubble; the dependent instruction then forwards from WB.
- memFreeze dominates: hazardStall is forced to 0 while memFreeze = 1.
- Memory-wait FSM (states IDLE, WAIT, RELEASE; counter cnt):
  - memFreeze = (IDLE & memAccess & MEM_WAIT != 0) | WAIT.
  - IDLE, memAccess and MEM_WAIT != 0: cnt <= 1; next state RELEASE if MEM_WAIT == 1, else WAIT.
  - WAIT: cnt <= cnt + 1; go to RELEASE when cnt == MEM_WAIT-1.
  - RELEASE: memFreeze = 0; the access leaves MEM; memAccess is ignored; go to IDLE.
  - Each access produces exactly MEM_WAIT freeze cycles.
  - Back-to-back accesses: the next access is seen in IDLE on the cycle after RELEASE.
  - MEM_WAIT = 0: FSM stays in IDLE and memFreeze is never asserted.
- stallCount: increments on every cycle with hazardStall | memFreeze; saturates at all-ones.
- Reset mid-freeze: next cycle is IDLE, memFreeze = 0, EX registers cleared.
- The register file writes in the first half-cycle, so a WB-stage producer never causes a stall.

Optional Feature:
FORWARDING_EN
- Defined: forwarding and load-use detection as described above.
- Undefined:
  - selSrc1 = selSrc2 = 00 constantly.
  - hazardStall = idValid & any used ID source equal to exeDest (with exeWbEn) or to memDest (with memWbEn).
  - The EX tracking registers may be optimised away.
  - The memory FSM and stallCount are unchanged.

Test Plan:
- Forward from MEM: EX instr reads R3, memDest=3 memWbEn=1 -> selSrc1=01. Also wbDest=3 wbWbEn=1 -> still 01 (MEM priority).
- Forward from WB: exSrc2=5, wbDest=5 wbWbEn=1, no MEM match -> selSrc2=10. With wbWbEn=0 -> 00.
- Load-use: exeDest=2 exeMemREn=1 exeWbEn=1, ID reads R2 -> hazardStall=1 for 1 cycle, stallCount 0->1. Next cycle the EX bubble gives selSrc=00. One cycle later the load is in WB -> selSrc=10.
- Memory wait, MEM_WAIT=2: memAccess=1 -> memFreeze high exactly 2 cycles, low on the 3rd. A hazard during the freeze -> hazardStall=0. stallCount +2.
- Back-to-back memAccess for 6 cycles, MEM_WAIT=2 -> memFreeze pattern 1,1,0,1,1,0.
- rst asserted in WAIT -> next cycle memFreeze=0, stallCount=0. Without FORWARDING_EN: MEM-stage match -> hazardStall=1, selSrc=00.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Execute-stage hazard unit: ALU source forwarding selects, stall detection, memory-wait freeze, stall counter.
// Define FORWARDING_EN for MEM/WB forwarding with load-use stalls; otherwise every RAW hazard on EX/MEM stalls.
module hazard_forward_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       idSrc1,
    input  logic [3:0]       idSrc2,
    input  logic             idUsesSrc1,
    input  logic             idUsesSrc2,
    input  logic             idValid,
    input  logic [3:0]       exeDest,
    input  logic             exeWbEn,
    input  logic             exeMemREn,
    input  logic [3:0]       memDest,
    input  logic             memWbEn,
    input  logic             memAccess,
    input  logic [3:0]       wbDest,
    input  logic             wbWbEn,
    output logic [1:0]       selSrc1,
    output logic [1:0]       selSrc2,
    output logic             hazardStall,
    output logic             memFreeze,
    output logic [CNT_W-1:0] stallCount
);

    localparam int WAIT_W = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MEM_WAIT - 1);
    localparam bit WAIT_ON = (MEM_WAIT != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } memState_t;

    memState_t          stateReg;
    logic [WAIT_W-1:0]  cntReg;
    logic [CNT_W-1:0]   stallCountReg;
    logic               accessStart;
    logic               rawHazard;
    logic [3:0]         idSrc [2];
    logic [1:0]         idUses;
    logic [1:0]         idHit;
    logic [1:0]         selSrc [2];

    assign idSrc[0] = idSrc1;
    assign idSrc[1] = idSrc2;
    assign idUses   = {idUsesSrc2, idUsesSrc1};
    assign selSrc1  = selSrc[0];
    assign selSrc2  = selSrc[1];

    // The freeze starts combinationally in IDLE so the access is held on its very first MEM cycle.
    assign accessStart = (stateReg == IDLE) && memAccess && WAIT_ON;
    assign memFreeze   = accessStart || (stateReg == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accessStart) begin
                        cntReg   <= WAIT_W'(1);
                        stateReg <= (MEM_WAIT == 1) ? RELEASE : WAIT;
                    end
                end
                WAIT: begin
                    cntReg <= cntReg + WAIT_W'(1);
                    if (cntReg == LAST_CNT) begin
                        stateReg <= RELEASE;
                    end
                end
                RELEASE: stateReg <= IDLE;
                default: stateReg <= IDLE;
            endcase
        end
    end

`ifdef FORWARDING_EN
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [3:0] exSrcReg;
            logic       exUsesReg;

            // EX copy of the source: held during a freeze, emptied when a bubble is inserted.
            always_ff @(posedge clk) begin
                if (rst) begin
                    exSrcReg  <= '0;
                    exUsesReg <= 1'b0;
                end else if (memFreeze) begin
                    exSrcReg  <= exSrcReg;
                    exUsesReg <= exUsesReg;
                end else if (hazardStall) begin
                    exUsesReg <= 1'b0;
                end else begin
                    exSrcReg  <= idSrc[gi];
                    exUsesReg <= idUses[gi] && idValid;
                end
            end

            assign selSrc[gi] = (exUsesReg && memWbEn && (memDest == exSrcReg)) ? 2'b01 :
                                (exUsesReg && wbWbEn  && (wbDest  == exSrcReg)) ? 2'b10 : 2'b00;
            assign idHit[gi]  = idUses[gi] && (idSrc[gi] == exeDest);
        end
    endgenerate

    // Only a load in EX is unresolvable by forwarding; ALU results reach EX from MEM next cycle.
    assign rawHazard = idValid && exeWbEn && exeMemREn && (|idHit);
`else
    logic unusedNoFwd;
    assign unusedNoFwd = ^{exeMemREn, wbDest, wbWbEn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign selSrc[gi] = 2'b00;
            // WB producers are excluded: the register file writes in the first half-cycle.
            assign idHit[gi]  = idUses[gi] &&
                                ((exeWbEn && (idSrc[gi] == exeDest)) ||
                                 (memWbEn && (idSrc[gi] == memDest)));
        end
    endgenerate

    assign rawHazard = idValid && (|idHit);
`endif

    assign hazardStall = rawHazard && !memFreeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCountReg <= '0;
        end else if ((hazardStall || memFreeze) && (stallCountReg != {CNT_W{1'b1}})) begin
            stallCountReg <= stallCountReg + CNT_W'(1);
        end
    end

    assign stallCount = stallCountReg;

endmodule
